// File: rtl/s5378_pkg.sv
// Shared types and parameter limits for the s5378 parity frame checker.
// Imported by the checker top level and its error tracker.
package s5378_pkg;

  typedef enum logic {
    ACCUM    = 1'b0,
    WAIT_EXP = 1'b1
  } state_t;

  localparam int FRAME_LEN_MIN = 2;
  localparam int FRAME_LEN_MAX = 256;
  localparam int THRESH_MIN    = 1;
  localparam int THRESH_MAX    = 15;
  localparam int CONSEC_W      = 4;

  function automatic bit params_ok(
    input int frame_len,
    input int thresh
  );
    return (frame_len >= FRAME_LEN_MIN) &&
           (frame_len <= FRAME_LEN_MAX) &&
           (thresh >= THRESH_MIN) &&
           (thresh <= THRESH_MAX);
  endfunction

endpackage

// File: rtl/s5378_err_tracker.sv
// Frame error bookkeeping: saturating error count, consecutive-bad
// run length and the sticky alarm with its set-over-clear priority.
module s5378_err_tracker
  import s5378_pkg::*;
#(
  parameter int ALARM_THRESH = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             i_verdict,
  input  logic             i_bad,
  input  logic             i_alarm_clr,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_alarm
);

  localparam logic [CONSEC_W-1:0] TH = CONSEC_W'(ALARM_THRESH);

  logic [CNT_W-1:0]    r_err_count;
  logic [CONSEC_W-1:0] r_consec;
  logic                r_alarm;
  logic [CONSEC_W-1:0] w_consec_nxt;
  logic                w_set;

  // Run length after this cycle's verdict, and whether it trips the alarm.
  always_comb begin
    w_consec_nxt = r_consec;
    if (i_verdict) begin
      if (i_bad) begin
        w_consec_nxt = (r_consec == TH) ? r_consec
                                        : r_consec + CONSEC_W'(1);
      end else begin
        w_consec_nxt = '0;
      end
    end
    w_set = i_verdict && i_bad && (w_consec_nxt == TH);
  end

  // Count/alarm state; an alarm set beats a same-cycle clear.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_err_count <= '0;
      r_consec    <= '0;
      r_alarm     <= 1'b0;
    end else begin
      if (i_verdict && i_bad && !(&r_err_count)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
      if (w_set) begin
        r_alarm  <= 1'b1;
        r_consec <= w_consec_nxt;
      end else if (i_alarm_clr) begin
        r_alarm  <= 1'b0;
        r_consec <= '0;
      end else begin
        r_consec <= w_consec_nxt;
      end
    end
  end

  assign o_err_count = r_err_count;
  assign o_alarm     = r_alarm;

endmodule

// File: rtl/s5378_parity_frame_checker.sv
// Frame-level parity checker behind the s5378 n240 parity cone:
// accumulates one frame of samples, then judges it against exp_parity.
module s5378_parity_frame_checker
  import s5378_pkg::*;
#(
  parameter int FRAME_LEN    = 16,
  parameter int ALARM_THRESH = 3,
  parameter int CNT_W        = 16
) (
  input  logic                         CK,
  input  logic                         RST,
  input  logic                         n240,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         exp_parity,
  input  logic                         exp_valid,
  output logic                         frame_done,
  output logic                         mismatch,
  output logic [CNT_W-1:0]             err_count,
  output logic                         alarm,
  input  logic                         alarm_clr,
  output logic [$clog2(FRAME_LEN)-1:0] sample_idx
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  if (!params_ok(FRAME_LEN, ALARM_THRESH)) begin : g_param_err
    $error("s5378_parity_frame_checker: parameter out of range");
  end

  state_t           r_state;
  logic             r_acc;
  logic [IDX_W-1:0] r_idx;
  logic             r_frame_done;
  logic             r_mismatch;
  logic             w_last;
  logic             w_bad;
  logic             w_verdict;

  assign w_last    = (r_idx == IDX_W'(FRAME_LEN - 1));
  assign w_bad     = r_acc ^ exp_parity;
  assign w_verdict = (r_state == WAIT_EXP) && exp_valid && !RST;

  // Frame FSM: accumulate parity, then wait for the expected value.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state      <= ACCUM;
      r_acc        <= 1'b0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_mismatch   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_mismatch   <= 1'b0;
      unique case (r_state)
        ACCUM: begin
          if (in_valid) begin
            r_acc <= r_acc ^ n240;
            if (w_last) begin
              r_state <= WAIT_EXP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        WAIT_EXP: begin
          if (exp_valid) begin
            r_frame_done <= 1'b1;
            r_mismatch   <= w_bad;
            r_acc        <= 1'b0;
            r_idx        <= '0;
            r_state      <= ACCUM;
          end
        end
      endcase
    end
  end

  s5378_err_tracker #(
    .ALARM_THRESH(ALARM_THRESH),
    .CNT_W       (CNT_W)
  ) u_err_tracker (
    .CK         (CK),
    .RST        (RST),
    .i_verdict  (w_verdict),
    .i_bad      (w_bad),
    .i_alarm_clr(alarm_clr),
    .o_err_count(err_count),
    .o_alarm    (alarm)
  );

  assign in_ready   = (r_state == ACCUM) && !RST;
  assign frame_done = r_frame_done;
  assign mismatch   = r_mismatch;
  assign sample_idx = r_idx;

endmodule

// File: tb/tb_s5378_parity_frame_checker.sv
// Scoreboard bench for s5378_parity_frame_checker (FRAME_LEN=4,
// ALARM_THRESH=2, CNT_W=2): directed scenarios then random traffic.
module tb_s5378_parity_frame_checker;

  localparam int FL   = 4;
  localparam int TH   = 2;
  localparam int CW   = 2;
  localparam int MAXE = (1 << CW) - 1;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          n240 = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          exp_parity = 1'b0;
  logic          exp_valid = 1'b0;
  logic          frame_done;
  logic          mismatch;
  logic [CW-1:0] err_count;
  logic          alarm;
  logic          alarm_clr = 1'b0;
  logic [1:0]    sample_idx;

  s5378_parity_frame_checker #(
    .FRAME_LEN   (FL),
    .ALARM_THRESH(TH),
    .CNT_W       (CW)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .n240      (n240),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_parity(exp_parity),
    .exp_valid (exp_valid),
    .frame_done(frame_done),
    .mismatch  (mismatch),
    .err_count (err_count),
    .alarm     (alarm),
    .alarm_clr (alarm_clr),
    .sample_idx(sample_idx)
  );

  always #5 CK = ~CK;

  typedef struct {
    bit mm;
    int err;
    bit alm;
  } verdict_t;

  verdict_t sb[$];
  bit       m_frame[$];
  int       m_err = 0;
  int       m_consec = 0;
  bit       m_alarm = 0;
  bit       m_in_rst = 1;
  int       errors = 0;
  int       checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame = list of accepted bits, parity = count mod 2.
  task automatic model(input bit iv, input bit n, input bit ev,
                       input bit ep, input bit clr, input bit rst);
    bit verdict = 0;
    bit bad = 0;
    bit set = 0;
    int ones = 0;
    if (rst) begin
      m_frame.delete();
      m_err = 0;
      m_consec = 0;
      m_alarm = 0;
      m_in_rst = 1;
      return;
    end
    m_in_rst = 0;
    if (m_frame.size() < FL) begin
      if (iv) m_frame.push_back(n);
    end else if (ev) begin
      foreach (m_frame[i]) ones += int'(m_frame[i]);
      bad = ((ones % 2) == 1) != ep;
      verdict = 1;
      m_frame.delete();
      if (bad) begin
        if (m_err < MAXE) m_err++;
        if (m_consec < TH) m_consec++;
        set = (m_consec == TH);
      end else begin
        m_consec = 0;
      end
      if (set) m_alarm = 1;
    end
    if (!set && clr) begin
      m_alarm = 0;
      m_consec = 0;
    end
    if (verdict) sb.push_back('{mm: bad, err: m_err, alm: m_alarm});
  endtask

  task automatic step(input bit iv, input bit n, input bit ev,
                      input bit ep, input bit clr, input bit rst);
    int exp_idx;
    in_valid = iv;
    n240 = n;
    exp_valid = ev;
    exp_parity = ep;
    alarm_clr = clr;
    RST = rst;
    @(posedge CK);
    model(iv, n, ev, ep, clr, rst);
    #1;
    exp_idx = (m_frame.size() == FL) ? FL - 1 : m_frame.size();
    chk("in_ready", int'(in_ready),
        int'(!m_in_rst && (m_frame.size() < FL)));
    chk("sample_idx", int'(sample_idx), exp_idx);
    chk("err_count", int'(err_count), m_err);
    chk("alarm", int'(alarm), int'(m_alarm));
    if (rst) begin
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_mismatch", int'(mismatch), 0);
    end
    chk("sb_backlog", int'(sb.size() > 1), 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
  endtask

  // bits[0] is fed first; stray exp_valid in sample gaps, and in_valid
  // held high while the verdict is delayed.
  task automatic frame(input bit [3:0] bits, input bit ep,
                       input int sgap, input int wgap, input bit clr);
    for (int i = 0; i < FL; i++) begin
      repeat (sgap) step(0, 0, 1, ~ep, 0, 0);
      step(1, bits[i], 0, 0, 0, 0);
    end
    repeat (wgap) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, ep, clr, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every frame_done must match the oldest expected verdict.
  always @(negedge CK) begin
    if (frame_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame_done", 1, 0);
      end else begin
        verdict_t v;
        v = sb.pop_front();
        chk("mismatch", int'(mismatch), int'(v.mm));
        chk("verdict_err_count", int'(err_count), v.err);
        chk("verdict_alarm", int'(alarm), int'(v.alm));
      end
    end else begin
      chk("mismatch_without_done", int'(mismatch), 0);
    end
  end

  initial begin
    bit iv;
    bit ev;
    bit clr;
    do_reset();
    frame(4'b1101, 1, 0, 0, 0);

    do_reset();
    frame(4'b0001, 0, 0, 0, 0);
    frame(4'b0001, 0, 0, 0, 0);

    do_reset();
    frame(4'b0001, 0, 0, 0, 0);
    frame(4'b0000, 0, 0, 0, 0);
    frame(4'b0001, 0, 0, 0, 0);

    do_reset();
    frame(4'b0001, 0, 0, 0, 0);
    frame(4'b0111, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    do_reset();
    frame(4'b1011, 0, 2, 5, 0);
    frame(4'b0110, 1, 1, 3, 0);

    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    frame(4'b1110, 1, 0, 0, 0);

    do_reset();
    repeat (5) frame(4'b0001, 0, 0, 0, 0);

    do_reset();
    for (int c = 0; c < 800; c++) begin
      iv  = ($urandom_range(0, 3) != 0);
      ev  = ($urandom_range(0, 2) == 0);
      clr = !ev && ($urandom_range(0, 15) == 0);
      step(iv, 1'($urandom), ev, 1'($urandom), clr,
           $urandom_range(0, 199) == 0);
    end

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s5378_parity_frame_checker.md
# s5378_parity_frame_checker

Sequential stage directly downstream of the s5378 9-input parity cone: consumes its `n240` parity bit once per valid sample and XOR-accumulates it over a fixed-length frame. At frame end it compares the result against an externally supplied expected parity. It counts mismatches and raises a sticky alarm after a run of consecutive bad frames. This is the first clocked stage wrapped around the combinational `n240` output.

## Interface
- `FRAME_LEN`, default 16: samples per frame; legal range 2..256.
- `ALARM_THRESH`, default 3: consecutive mismatching frames that set `alarm`; legal range 1..15.
- `CNT_W`, default 16: width of `err_count`.
- `CK`  in  1  single clock; all logic is rising-edge.
- `RST`  in  1  synchronous, active-high reset.
- `n240`  in  1  parity sample from the upstream cone.
- `in_valid`  in  1  `n240` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle.
- `exp_parity`  in  1  expected frame parity.
- `exp_valid`  in  1  `exp_parity` is valid this cycle.
- `frame_done`  out  1  one-cycle pulse when a frame verdict is produced.
- `mismatch`  out  1  one-cycle pulse, coincident with `frame_done`, when the verdict is bad.
- `err_count`  out  CNT_W  total mismatching frames; saturates at all-ones.
- `alarm`  out  1  sticky consecutive-error alarm.
- `alarm_clr`  in  1  clears `alarm` and the consecutive-mismatch count.
- `sample_idx`  out  $clog2(FRAME_LEN)  index of the next sample within the current frame.

## Operation
- FSM states:
  - `ACCUM`: `in_ready` = 1. A sample is accepted when `in_valid && in_ready`. On acceptance, `acc <= acc ^ n240` and `sample_idx` increments. On acceptance at `sample_idx == FRAME_LEN-1`, go to `WAIT_EXP`.
  - `WAIT_EXP`: `in_ready` = 0. Idle until `exp_valid`. On `exp_valid`:
    - `bad = acc ^ exp_parity`.
    - Register `frame_done` = 1 and `mismatch` = `bad`.
    - Clear `acc` and `sample_idx`, then return to `ACCUM`.
- `exp_valid` while in `ACCUM` is ignored. `exp_valid` is not held for later use.
- Error bookkeeping, applied in the verdict cycle:
  - `bad`: `err_count` increments unless already all-ones. `consec` increments, saturating at `ALARM_THRESH`.
  - Match: `consec` is reset to 0.
  - When `consec` reaches `ALARM_THRESH`, `alarm` is set.
- `alarm_clr` clears `alarm` and `consec`. It does not clear `err_count`.
- If `alarm_clr` arrives in the same cycle as a verdict that sets `alarm`, the set wins and `consec` takes its post-verdict value.
- Only `RST` clears `err_count`.
- `sample_idx` wraps to 0 only through the transition out of `WAIT_EXP`. It never exceeds `FRAME_LEN-1`.

## Timing
- Reset values:
  - `RST` high: state = `ACCUM`, `acc` = 0, `sample_idx` = 0, `consec` = 0.
  - All outputs are 0, including `in_ready`. `in_ready` is gated by `RST`.
- `in_ready` is 1 in the first cycle after `RST` deasserts.
- `RST` asserted mid-frame or in `WAIT_EXP` discards the partial frame. No `frame_done` is produced for that frame.
- `in_ready` is a combinational function of state and `RST`. It has no dependency on `in_valid`.
- Latency:
  - The last sample is accepted in cycle T, so `WAIT_EXP` begins in T+1.
  - `exp_valid` is sampled in cycle E ≥ T+1.
  - `frame_done`/`mismatch`, the new `err_count` and the new `alarm` are all visible in E+1.
- Back-to-back operation: `in_ready` = 1 in E+1. The minimum frame period is `FRAME_LEN`+1 cycles.
- `frame_done` and `mismatch` are high for exactly one cycle per verdict.

## Structure
- Shared package `s5378_pkg`:
  - FSM state enum `{ACCUM, WAIT_EXP}`.
  - Parameter-range checking constants.
- Sub-module `s5378_err_tracker`: holds `err_count`, `consec` and `alarm`, including the saturation and clear/set priority rules. Inputs: a verdict strobe, `bad`, and `alarm_clr`.
- The top level holds the FSM, `acc` and `sample_idx`.

## Test plan
Unless stated otherwise, `FRAME_LEN`=4 and `ALARM_THRESH`=2.
- **Good frame:** reset, then feed `n240` = 1,0,1,1 with continuous `in_valid`, then `exp_parity`=1 → `frame_done`=1, `mismatch`=0, `err_count`=0; `in_ready`=0 only while in `WAIT_EXP`.
- **Alarm:** two consecutive frames with `n240`=1,0,0,0 and `exp_parity`=0 → `mismatch` pulses on both; `err_count`=2; `alarm`=1 in the cycle after the second verdict.
- **Clear vs. set priority:**
  - Bad frame, good frame, bad frame → `alarm` stays 0 and `err_count`=2.
  - `alarm_clr` in the same cycle as a verdict that reaches the threshold → `alarm`=1.
- **Gaps and stalls:** gaps in `in_valid`, `exp_valid` pulsed during `ACCUM`, and `exp_valid` delayed 5 cycles in `WAIT_EXP` → stray `exp_valid` ignored; exactly one verdict per frame; `sample_idx` sequence 0,1,2,3,0.
- **Reset mid-frame:** `RST` asserted after 2 samples → no `frame_done`; all outputs 0; the next full frame is judged from `acc`=0.
- **Saturation:** `CNT_W`=2 with 5 bad frames → `err_count` holds at 3.
